button_counter: RTL and testbench

// - Counts debounced rising edges of an asynchronous push-button input as a
//   4-digit packed-BCD value (0000-9999) for a 7-segment display driver.
// - Sits between the board button pin and the display multiplexer. Counting
//   is gated by an enable from the run-control logic.
//

---
 rtl/button_counter.sv | 63 ++++++
 tb/tb_button_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/button_counter.sv
// button_counter: counts debounced button presses as a 4-digit packed-BCD value.
// Optional debounce filter between synchronizer and edge detect, enabled by `define DEBOUNCE_EN.
module button_counter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button,
    input  logic        enable,
    output logic [15:0] digits
);
    logic s1, s2, lvl, prev, pulse, carry;
    logic [15:0] next_digits;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= button;
            s2 <= s1;
        end

`ifdef DEBOUNCE_EN
    // cnt counts clks that s2 has differed from lvl; any bounce back clears it
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            lvl <= 1'b0;
            cnt <= '0;
        end else if (s2 == lvl)
            cnt <= '0;
        else if (cnt == 16'(DEBOUNCE_CYCLES)) begin
            lvl <= s2;
            cnt <= '0;
        end else
            cnt <= cnt + 16'd1;
`else
    always_ff @(posedge clk or posedge reset)
        if (reset) lvl <= 1'b0;
        else lvl <= s2;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) prev <= 1'b0;
        else prev <= lvl;

    assign pulse = lvl & ~prev;

    always_comb begin
        carry = 1'b1;
        next_digits = digits;
        for (int i = 0; i < 4; i++) begin
            next_digits[4*i +: 4] = carry ? (digits[4*i +: 4] == 4'd9 ? 4'd0 : digits[4*i +: 4] + 4'd1)
                                          : digits[4*i +: 4];
            carry = carry & (digits[4*i +: 4] == 4'd9);
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) digits <= 16'h0000;
        else if (pulse & enable) digits <= next_digits;
endmodule

// File: tb/tb_button_counter.sv
// tb_button_counter: directed self-checking bench for button_counter.
// Glitch tests are built only with DEBOUNCE_EN defined.
module tb_button_counter;
`ifdef DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int PW = DB + 1;

    logic clk = 1'b0, reset = 1'b1, button = 1'b0, enable = 1'b1;
    logic [15:0] digits;
    int checks = 0, errors = 0, n = 0;

    button_counter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .button(button), .enable(enable), .digits(digits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic press(input int h, input int l);
        button = 1'b1;
        tick(h);
        button = 1'b0;
        tick(l);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] bcd_ok(input logic [15:0] d);
        return {15'd0, d[15:12] <= 4'd9 && d[11:8] <= 4'd9 && d[7:4] <= 4'd9 && d[3:0] <= 4'd9};
    endfunction

    task automatic fast_to(input int target);
        while (n < target) begin
            press(PW, PW);
            n++;
            check("nibble", bcd_ok(digits), 16'd1);
        end
        tick(4 + DB);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(5);
        check("in_reset", digits, 16'h0000);
        reset = 1'b0;
        tick(2);
        n = 0;
    endtask

    initial begin
        tick(1);
        do_reset();
        check("after_reset", digits, 16'h0000);

        // first press: latency 3 edges (+DB) from the first edge seeing button high
        button = 1'b1;
        repeat (3 + DB) @(posedge clk);
        #1 check("latency_early", digits, 16'h0000);
        @(posedge clk);
        #1 check("latency_hit", digits, 16'h0001);
        tick(9 - DB);
        button = 1'b0;
        tick(10);
        check("one_press", digits, 16'h0001);

        press(10, 10);
        press(10, 10);
        check("three_presses", digits, 16'h0003);
        button = 1'b1;
        tick(50);
        check("held_mid", digits, 16'h0004);
        tick(50);
        button = 1'b0;
        tick(10);
        check("held_release", digits, 16'h0004);

        enable = 1'b0;
        press(10, 10);
        check("enable_off", digits, 16'h0004);
        enable = 1'b1;
        tick(5);
        check("enable_toggle", digits, 16'h0004);
        press(10, 10);
        check("enable_on", digits, 16'h0005);

        do_reset();
        for (int i = 0; i < 9; i++) press(10, 10);
        n = 9;
        check("nine", digits, 16'h0009);
        press(10, 10);
        n = 10;
        check("carry_10", digits, 16'h0010);
        fast_to(99);
        check("at_99", digits, to_bcd(99));
        fast_to(100);
        check("carry_100", digits, 16'h0100);
        fast_to(1234);
        check("at_1234", digits, 16'h1234);
        fast_to(9999);
        check("at_9999", digits, 16'h9999);
        press(10, 10);
        check("wrap", digits, 16'h0000);

        press(10, 10);
        press(10, 10);
        check("pre_async", digits, 16'h0002);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", digits, 16'h0000);
        tick(2);
        reset = 1'b0;
        tick(10);
        check("after_async", digits, 16'h0000);

        button = 1'b1;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(8 + DB);
        check("held_thru_reset", digits, 16'h0001);
        button = 1'b0;
        tick(10);
        check("held_thru_release", digits, 16'h0001);

        button = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);
        check("reset_mid_press", digits, 16'h0000);
        button = 1'b0;
        reset = 1'b0;
        tick(10);
        check("after_mid_press", digits, 16'h0000);

`ifdef DEBOUNCE_EN
        press(2, 20);
        check("glitch", digits, 16'h0000);
        for (int i = 0; i < 3; i++) press(1, 1);
        press(20, 20);
        check("bounce", digits, 16'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
